// File: rtl/filter_ifmap_mem_if.sv
// Load-side write channels, end-of-load token and the two outgoing packet streams.
// master = the loader/consumer side, slave = the filter/ifmap memory block.
interface filter_ifmap_mem_if #(
  parameter int WIDTH_PKT = 32
);
  logic                 filter_in_valid;
  logic                 filter_in_ready;
  logic [4:0]           filter_in_addr;
  logic [7:0]           filter_in_data;
  logic                 ifmap_in_valid;
  logic                 ifmap_in_ready;
  logic [9:0]           ifmap_in_addr;
  logic                 ifmap_in_data;
  logic                 load_done_valid;
  logic                 load_done_ready;
  logic                 filter_out_valid;
  logic                 filter_out_ready;
  logic [WIDTH_PKT-1:0] filter_out_data;
  logic                 ifmap_out_valid;
  logic                 ifmap_out_ready;
  logic [WIDTH_PKT-1:0] ifmap_out_data;
  logic                 done;

  modport master (
    output filter_in_valid, filter_in_addr, filter_in_data,
    output ifmap_in_valid, ifmap_in_addr, ifmap_in_data,
    output load_done_valid, filter_out_ready, ifmap_out_ready,
    input  filter_in_ready, ifmap_in_ready, load_done_ready,
    input  filter_out_valid, filter_out_data, ifmap_out_valid, ifmap_out_data, done
  );

  modport slave (
    input  filter_in_valid, filter_in_addr, filter_in_data,
    input  ifmap_in_valid, ifmap_in_addr, ifmap_in_data,
    input  load_done_valid, filter_out_ready, ifmap_out_ready,
    output filter_in_ready, ifmap_in_ready, load_done_ready,
    output filter_out_valid, filter_out_data, ifmap_out_valid, ifmap_out_data, done
  );
endinterface

// File: rtl/filter_ifmap_mem.sv
// Filter/ifmap staging memory: loads weights and spikes, then streams both as tagged packets.
// Packets are registered (1-cycle after load_done); each stream stalls independently on its ready.
module filter_ifmap_mem #(
  parameter int DEPTH_F    = 5,
  parameter int DEPTH_I    = 25,
  parameter int WIDTH_PKT  = 32,
  parameter int WIDTH_DATA = 13
) (
  input logic               clk,
  input logic               rst_n,
  filter_ifmap_mem_if.slave bus
);
  localparam int        FN     = DEPTH_F * DEPTH_F;
  localparam int        IN     = DEPTH_I * DEPTH_I;
  localparam logic [9:0] F_LAST = 10'(FN - 1);
  localparam logic [9:0] I_LAST = 10'(IN - 1);

  typedef enum logic [1:0] {LOAD, STREAM, DONE} state_t;

  state_t               state_q, state_d;
  logic [7:0]           filter_mem_q [FN];
  logic [7:0]           filter_mem_d [FN];
  logic                 ifmap_mem_q  [IN];
  logic                 ifmap_mem_d  [IN];
  logic [9:0]           f_cnt_q, f_cnt_d, i_cnt_q, i_cnt_d;
  logic                 f_vld_q, f_vld_d, i_vld_q, i_vld_d;
  logic [WIDTH_PKT-1:0] f_dat_q, f_dat_d, i_dat_q, i_dat_d;
  logic [9:0]           f_nxt, i_nxt;
  logic [7:0]           f_rd;
  logic                 i_rd;
  logic                 load_ok;

  function automatic logic [WIDTH_PKT-1:0] mk_pkt(input logic [1:0] typ, input logic [9:0] idx,
                                                  input logic [7:0] dat);
    logic [WIDTH_PKT-1:0] p;
    p                   = '0;
    p[31:30]            = typ;
    p[22:13]            = idx;
    p[WIDTH_DATA-1:0]   = WIDTH_DATA'(dat);
    return p;
  endfunction

  assign load_ok = (state_q == LOAD);

  always_comb begin
    state_d      = state_q;
    filter_mem_d = filter_mem_q;
    ifmap_mem_d  = ifmap_mem_q;
    f_cnt_d      = f_cnt_q;
    i_cnt_d      = i_cnt_q;
    f_vld_d      = f_vld_q;
    i_vld_d      = i_vld_q;
    f_dat_d      = f_dat_q;
    i_dat_d      = i_dat_q;
    f_nxt        = f_cnt_q + 10'd1;
    i_nxt        = i_cnt_q + 10'd1;
    f_rd         = '0;
    i_rd         = 1'b0;

    // Out-of-range addresses match no entry, so the write is silently dropped.
    for (int i = 0; i < FN; i++) begin
      if (load_ok && bus.filter_in_valid && 32'(bus.filter_in_addr) == i)
        filter_mem_d[i] = bus.filter_in_data;
      if (32'(f_nxt) == i)
        f_rd = filter_mem_q[i];
    end
    for (int i = 0; i < IN; i++) begin
      if (load_ok && bus.ifmap_in_valid && 32'(bus.ifmap_in_addr) == i)
        ifmap_mem_d[i] = bus.ifmap_in_data;
      if (32'(i_nxt) == i)
        i_rd = ifmap_mem_q[i];
    end

    case (state_q)
      LOAD: begin
        if (bus.load_done_valid) begin
          // First packets use the _d memories so writes in the load_done cycle are seen.
          state_d = STREAM;
          f_cnt_d = '0;
          i_cnt_d = '0;
          f_vld_d = 1'b1;
          i_vld_d = 1'b1;
          f_dat_d = mk_pkt(2'b01, 10'd0, filter_mem_d[0]);
          i_dat_d = mk_pkt(2'b10, 10'd0, {7'd0, ifmap_mem_d[0]});
        end
      end
      STREAM: begin
        if (f_vld_q && bus.filter_out_ready) begin
          if (f_cnt_q == F_LAST) begin
            f_vld_d = 1'b0;
          end else begin
            f_cnt_d = f_nxt;
            f_dat_d = mk_pkt(2'b01, f_nxt, f_rd);
          end
        end
        if (i_vld_q && bus.ifmap_out_ready) begin
          if (i_cnt_q == I_LAST) begin
            i_vld_d = 1'b0;
          end else begin
            i_cnt_d = i_nxt;
            i_dat_d = mk_pkt(2'b10, i_nxt, {7'd0, i_rd});
          end
        end
        if (!f_vld_d && !i_vld_d)
          state_d = DONE;
      end
      DONE:    state_d = DONE;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      filter_mem_q <= '{default: '0};
      ifmap_mem_q  <= '{default: '0};
      f_cnt_q      <= '0;
      i_cnt_q      <= '0;
      f_vld_q      <= 1'b0;
      i_vld_q      <= 1'b0;
      f_dat_q      <= '0;
      i_dat_q      <= '0;
    end else begin
      state_q      <= state_d;
      filter_mem_q <= filter_mem_d;
      ifmap_mem_q  <= ifmap_mem_d;
      f_cnt_q      <= f_cnt_d;
      i_cnt_q      <= i_cnt_d;
      f_vld_q      <= f_vld_d;
      i_vld_q      <= i_vld_d;
      f_dat_q      <= f_dat_d;
      i_dat_q      <= i_dat_d;
    end
  end

  assign bus.filter_in_ready  = load_ok;
  assign bus.ifmap_in_ready   = load_ok;
  assign bus.load_done_ready  = load_ok;
  assign bus.filter_out_valid = f_vld_q;
  assign bus.filter_out_data  = f_dat_q;
  assign bus.ifmap_out_valid  = i_vld_q;
  assign bus.ifmap_out_data   = i_dat_q;
  assign bus.done             = (state_q == DONE);
endmodule

// File: tb/tb_filter_ifmap_mem.sv
// Directed bench for filter_ifmap_mem with a 3x3 filter and 5x5 ifmap.
module tb_filter_ifmap_mem;
  localparam int NF = 9;
  localparam int NI = 25;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vec = 0;
  int   errs = 0;
  logic [7:0] fm [NF];
  logic       im [NI];

  filter_ifmap_mem_if #(.WIDTH_PKT(32)) bus ();

  filter_ifmap_mem #(.DEPTH_F(3), .DEPTH_I(5), .WIDTH_PKT(32), .WIDTH_DATA(13)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pkt(input logic [1:0] t, input int idx, input logic [7:0] d);
    logic [9:0] ix;
    ix = 10'(idx);
    return {t, 7'd0, ix, 5'd0, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NF; i++) fm[i] = 8'd0;
    for (int i = 0; i < NI; i++) im[i] = 1'b0;
  endtask

  task automatic check_readys(input logic exp);
    chk("filter_in_ready", 32'(bus.filter_in_ready), 32'(exp));
    chk("ifmap_in_ready", 32'(bus.ifmap_in_ready), 32'(exp));
    chk("load_done_ready", 32'(bus.load_done_ready), 32'(exp));
  endtask

  task automatic check_idle_outputs();
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_f_vld", 32'(bus.filter_out_valid), 0);
    chk("rst_i_vld", 32'(bus.ifmap_out_valid), 0);
    chk("rst_f_dat", bus.filter_out_data, 0);
    chk("rst_i_dat", bus.ifmap_out_data, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_readys(1'b1);
    clear_model();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs();
    release_reset();
  endtask

  task automatic wr_filter(input int a, input logic [7:0] d, input logic exp_rdy);
    bus.filter_in_valid = 1'b1;
    bus.filter_in_addr  = 5'(a);
    bus.filter_in_data  = d;
    #1;
    chk("wr_filter_ready", 32'(bus.filter_in_ready), 32'(exp_rdy));
    @(negedge clk);
    bus.filter_in_valid = 1'b0;
    if (exp_rdy && a < NF) fm[a] = d;
  endtask

  task automatic wr_ifmap(input int a, input logic d, input logic exp_rdy);
    bus.ifmap_in_valid = 1'b1;
    bus.ifmap_in_addr  = 10'(a);
    bus.ifmap_in_data  = d;
    #1;
    chk("wr_ifmap_ready", 32'(bus.ifmap_in_ready), 32'(exp_rdy));
    @(negedge clk);
    bus.ifmap_in_valid = 1'b0;
    if (exp_rdy && a < NI) im[a] = d;
  endtask

  task automatic send_load_done();
    bus.load_done_valid = 1'b1;
    #1;
    chk("load_done_ready", 32'(bus.load_done_ready), 1);
    @(negedge clk);
    bus.load_done_valid = 1'b0;
  endtask

  // Filter address 8, ifmap address 24 and the load_done token all in one cycle.
  task automatic wr_last_and_done(input logic [7:0] fd, input logic id);
    bus.filter_in_valid = 1'b1;
    bus.filter_in_addr  = 5'd8;
    bus.filter_in_data  = fd;
    bus.ifmap_in_valid  = 1'b1;
    bus.ifmap_in_addr   = 10'd24;
    bus.ifmap_in_data   = id;
    bus.load_done_valid = 1'b1;
    #1;
    check_readys(1'b1);
    @(negedge clk);
    bus.filter_in_valid = 1'b0;
    bus.ifmap_in_valid  = 1'b0;
    bus.load_done_valid = 1'b0;
    fm[8] = fd;
    im[24] = id;
  endtask

  // Called on the negedge right after load_done transferred; checks every cycle.
  task automatic stream(input int f_stall_at, input int f_stall_len, input int rst_at_i);
    int fidx = 0;
    int iidx = 0;
    int stalled = 0;
    bit fin = 1'b0;
    logic f_rdy;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      f_rdy = 1'b1;
      if (fidx == f_stall_at && stalled < f_stall_len) begin
        f_rdy = 1'b0;
        stalled++;
      end
      bus.filter_out_ready = f_rdy;
      bus.ifmap_out_ready  = 1'b1;
      if (rst_at_i >= 0 && iidx == rst_at_i) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs();
        fin = 1'b1;
      end else begin
        #1;
        chk("f_vld", 32'(bus.filter_out_valid), 32'(fidx < NF));
        chk("i_vld", 32'(bus.ifmap_out_valid), 32'(iidx < NI));
        chk("ld_rdy_stream", 32'(bus.filter_in_ready), 0);
        chk("done_timing", 32'(bus.done), 32'(fidx == NF && iidx == NI));
        if (fidx < NF) begin
          chk($sformatf("f_pkt%0d", fidx), bus.filter_out_data, pkt(2'b01, fidx, fm[fidx]));
          if (f_rdy) fidx++;
        end
        if (iidx < NI) begin
          chk($sformatf("i_pkt%0d", iidx), bus.ifmap_out_data, pkt(2'b10, iidx, {7'd0, im[iidx]}));
          iidx++;
        end
        if (bus.done) fin = 1'b1;
        else @(negedge clk);
      end
    end
    if (!fin) begin
      errs++;
      $error("FAIL stream_timeout: observed fidx=%0d iidx=%0d expected completion", fidx, iidx);
    end
    bus.filter_out_ready = 1'b1;
  endtask

  initial begin
    bus.filter_in_valid  = 1'b0;
    bus.filter_in_addr   = '0;
    bus.filter_in_data   = '0;
    bus.ifmap_in_valid   = 1'b0;
    bus.ifmap_in_addr    = '0;
    bus.ifmap_in_data    = 1'b0;
    bus.load_done_valid  = 1'b0;
    bus.filter_out_ready = 1'b1;
    bus.ifmap_out_ready  = 1'b1;
    clear_model();

    // Reset state, then explicit pulse
    #2;
    check_idle_outputs();
    release_reset();
    do_reset();

    // Basic load (with an overwrite of filter 0) and full concurrent stream
    wr_filter(0, 8'd77, 1'b1);
    for (int a = 0; a < 8; a++) wr_filter(a, 8'(10 + a), 1'b1);
    for (int a = 0; a < 24; a++) wr_ifmap(a, (a % 2) == 0, 1'b1);
    wr_last_and_done(8'd18, 1'b1);
    chk("first_f_pkt", bus.filter_out_data, 32'h4000000A);
    chk("first_i_pkt", bus.ifmap_out_data, 32'h80000001);
    stream(-1, 0, -1);
    repeat (3) @(negedge clk);
    chk("done_sticky", 32'(bus.done), 1);
    wr_filter(1, 8'd99, 1'b0);
    chk("done_after_write", 32'(bus.done), 1);

    // Filter stall mid-stream with a write attempt held during streaming
    do_reset();
    for (int a = 0; a < NF; a++) wr_filter(a, 8'(20 + 3 * a), 1'b1);
    for (int a = 0; a < NI; a++) wr_ifmap(a, (a % 3) == 0, 1'b1);
    send_load_done();
    bus.filter_in_valid = 1'b1;
    bus.filter_in_addr  = 5'd2;
    bus.filter_in_data  = 8'hEE;
    stream(4, 5, -1);
    bus.filter_in_valid = 1'b0;

    // Out-of-range writes dropped, all streamed data reads as zero
    do_reset();
    wr_filter(9, 8'h55, 1'b1);
    wr_ifmap(25, 1'b1, 1'b1);
    send_load_done();
    stream(-1, 0, -1);

    // Reset at ifmap index 12, then a fresh load and stream
    do_reset();
    for (int a = 0; a < NF; a++) wr_filter(a, 8'(a + 1), 1'b1);
    for (int a = 0; a < NI; a++) wr_ifmap(a, 1'b1, 1'b1);
    send_load_done();
    stream(-1, 0, 12);
    release_reset();
    for (int a = 0; a < NF; a++) wr_filter(a, 8'(200 + a), 1'b1);
    for (int a = 0; a < NI; a++) wr_ifmap(a, (a % 4) == 1, 1'b1);
    send_load_done();
    stream(-1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
